// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider (DIV/DIVU), level start / ready handshake
// Optional build macro DIV_ZERO_FAST_EN: divide-by-zero bypasses the iteration loop.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_sign,
    input  logic               div_start_i,
    input  logic [WIDTH-1:0]   div_op1,
    input  logic [WIDTH-1:0]   div_op2,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;

    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        op1_neg   = div_sign & div_op1[WIDTH-1];
        op2_neg   = div_sign & div_op2[WIDTH-1];
        op1_abs   = op1_neg ? -div_op1 : div_op1;
        op2_abs   = op2_neg ? -div_op2 : div_op2;
        rem_shift = {rem, dvd[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dvs});
        // When q_bit is set the difference is below dvs, so WIDTH bits hold it.
        rem_sub   = rem_shift[WIDTH-1:0] - dvs;
        quo_fix   = neg_q ? -dvd : dvd;
        rem_fix   = neg_r ? -rem : rem;
    end

    // The dividend register doubles as the quotient: q bits enter at the LSB as dividend bits leave.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_ready <= 1'b0;
            result    <= '0;
        end else if (!div_start_i) begin
            state     <= S_IDLE;
            div_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    dvs   <= op2_abs;
                    neg_q <= op1_neg ^ op2_neg;
                    neg_r <= op1_neg;
                    count <= '0;
`ifdef DIV_ZERO_FAST_EN
                    if (div_op2 == '0) begin
                        dvd   <= '1;
                        rem   <= op1_abs;
                        state <= S_SIGN;
                    end else begin
                        dvd   <= op1_abs;
                        rem   <= '0;
                        state <= S_CALC;
                    end
`else
                    dvd   <= op1_abs;
                    rem   <= '0;
                    state <= S_CALC;
`endif
                end
                S_CALC: begin
                    rem   <= q_bit ? rem_sub : rem_shift[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], q_bit};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= S_SIGN;
                end
                S_SIGN: begin
                    result    <= {rem_fix, quo_fix};
                    div_ready <= 1'b1;
                    state     <= S_DONE;
                end
                default: begin
                    state <= S_DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed-vector bench for div_iter
module tb_div_iter;
    logic        clk;
    logic        resetn;
    logic        div_sign;
    logic        div_start_i;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_ready;
    logic [63:0] result;

    int n_vec;
    int n_err;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_iter #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .div_sign    (div_sign),
        .div_start_i (div_start_i),
        .div_op1     (div_op1),
        .div_op2     (div_op2),
        .div_ready   (div_ready),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise start, run to just before the expected ready edge, then one more edge.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int lat, output logic early, output logic rdy,
                          output logic [63:0] res);
        @(negedge clk);
        div_sign    = sgn;
        div_op1     = a;
        div_op2     = b;
        div_start_i = 1'b1;
        repeat (lat) @(posedge clk);
        #1 early = div_ready;
        @(posedge clk);
        #1 rdy = div_ready;
        res = result;
    endtask

    task automatic drop_start();
        @(negedge clk);
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        div_start_i = 1'b0;
        div_sign    = 1'b0;
        div_op1     = '0;
        div_op2     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (div_ready !== 1'b0 || result !== 64'd0) begin
            n_err++;
            $display("FAIL reset: ready=%b result=%h want ready=0 result=0", div_ready, result);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (div_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: ready=%b want 0", div_ready);
        end
    endtask

    task automatic test_divu_basic();
        logic e, r;
        logic [63:0] res;
        do_div(1'b0, 32'd100, 32'd7, 33, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1) begin
            n_err++;
            $display("FAIL divu_latency: ready@32=%b ready@33=%b want 0,1", e, r);
        end
        n_vec++;
        if (res !== {32'd2, 32'd14}) begin
            n_err++;
            $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (div_ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
                n_err++;
                $display("FAIL divu_hold: ready=%b result=%h want 1 %h", div_ready, result, {32'd2, 32'd14});
            end
        end
        drop_start();
        n_vec++;
        if (div_ready !== 1'b0 || result !== {32'd2, 32'd14}) begin
            n_err++;
            $display("FAIL divu_release: ready=%b result=%h want 0 %h", div_ready, result, {32'd2, 32'd14});
        end
    endtask

    task automatic test_signed();
        logic e, r;
        logic [63:0] res;
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 33, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_err++;
            $display("FAIL div_m7_2: early=%b ready=%b got %h want 0 1 %h", e, r, res, 64'hFFFFFFFF_FFFFFFFD);
        end
        drop_start();
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 33, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1 || res !== 64'h00000001_FFFFFFFD) begin
            n_err++;
            $display("FAIL div_7_m2: early=%b ready=%b got %h want 0 1 %h", e, r, res, 64'h00000001_FFFFFFFD);
        end
        drop_start();
    endtask

    task automatic test_overflow();
        logic e, r;
        logic [63:0] res;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 33, e, r, res);
        n_vec++;
        if (r !== 1'b1 || res !== 64'h00000000_80000000) begin
            n_err++;
            $display("FAIL div_overflow: ready=%b got %h want 1 %h", r, res, 64'h00000000_80000000);
        end
        drop_start();
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 33, e, r, res);
        n_vec++;
        if (r !== 1'b1 || res !== 64'h80000000_00000000) begin
            n_err++;
            $display("FAIL divu_big: ready=%b got %h want 1 %h", r, res, 64'h80000000_00000000);
        end
        drop_start();
    endtask

    task automatic test_div_zero();
        logic e, r;
        logic [63:0] res;
        do_div(1'b0, 32'd5, 32'd0, ZLAT, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1) begin
            n_err++;
            $display("FAIL divu_zero_latency: early=%b ready=%b want 0,1 at latency %0d", e, r, ZLAT);
        end
        n_vec++;
        if (res !== 64'h00000005_FFFFFFFF) begin
            n_err++;
            $display("FAIL divu_5_0: got %h want %h", res, 64'h00000005_FFFFFFFF);
        end
        drop_start();
        do_div(1'b1, 32'hFFFFFFFB, 32'd0, ZLAT, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1 || res !== 64'hFFFFFFFB_00000001) begin
            n_err++;
            $display("FAIL div_m5_0: early=%b ready=%b got %h want 0 1 %h", e, r, res, 64'hFFFFFFFB_00000001);
        end
        drop_start();
    endtask

    task automatic test_abort();
        logic e, r;
        logic [63:0] res;
        @(negedge clk);
        div_sign    = 1'b0;
        div_op1     = 32'd1000;
        div_op2     = 32'd3;
        div_start_i = 1'b1;
        repeat (10) @(posedge clk);
        drop_start();
        n_vec++;
        if (div_ready !== 1'b0 || result !== 64'hFFFFFFFB_00000001) begin
            n_err++;
            $display("FAIL abort: ready=%b result=%h want 0 %h", div_ready, result, 64'hFFFFFFFB_00000001);
        end
        do_div(1'b0, 32'd9, 32'd3, 33, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1 || res !== {32'd0, 32'd3}) begin
            n_err++;
            $display("FAIL abort_restart: early=%b ready=%b got %h want 0 1 %h", e, r, res, {32'd0, 32'd3});
        end
        drop_start();
    endtask

    task automatic test_reset_mid();
        logic e, r;
        logic [63:0] res;
        @(negedge clk);
        div_sign    = 1'b0;
        div_op1     = 32'd50;
        div_op2     = 32'd4;
        div_start_i = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        resetn      = 1'b0;
        div_start_i = 1'b0;
        #1;
        n_vec++;
        if (div_ready !== 1'b0 || result !== 64'd0) begin
            n_err++;
            $display("FAIL reset_mid: ready=%b result=%h want 0 0", div_ready, result);
        end
        @(negedge clk);
        resetn = 1'b1;
        do_div(1'b0, 32'd100, 32'd7, 33, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1 || res !== {32'd2, 32'd14}) begin
            n_err++;
            $display("FAIL after_reset_div: early=%b ready=%b got %h want 0 1 %h", e, r, res, {32'd2, 32'd14});
        end
        drop_start();
    endtask

    task automatic test_back_to_back();
        logic e, r;
        logic [63:0] res;
        do_div(1'b0, 32'd1000, 32'd10, 33, e, r, res);
        n_vec++;
        if (r !== 1'b1 || res !== {32'd0, 32'd100}) begin
            n_err++;
            $display("FAIL b2b_first: ready=%b got %h want 1 %h", r, res, {32'd0, 32'd100});
        end
        drop_start();
        do_div(1'b1, 32'hFFFFFF9C, 32'd9, 33, e, r, res);
        n_vec++;
        if (e !== 1'b0 || r !== 1'b1 || res !== 64'hFFFFFFFF_FFFFFFF5) begin
            n_err++;
            $display("FAIL b2b_second: early=%b ready=%b got %h want 0 1 %h", e, r, res, 64'hFFFFFFFF_FFFFFFF5);
        end
        drop_start();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
